// File: rtl/id_stage.sv
// Decode stage: register bank, immediate extension, jump target and the ID/EX pipeline register.
// One-step latency; a load-use hazard raises o_stall. Defining ID_STAGE_BYPASS_EN forwards same-cycle writeback data to reads.
module id_stage #(
  parameter int BITS_SIZE      = 32,
  parameter int BITS_REGS      = 5,
  parameter int REG_SIZE       = 32,
  parameter int BITS_JUMP      = 26,
  parameter int BITS_INMEDIATE = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_step,
  input  logic                      i_flush,
  input  logic                      i_valid,
  input  logic                      i_mem_read,
  input  logic [BITS_REGS-1:0]      i_addr_rs,
  input  logic [BITS_REGS-1:0]      i_addr_rt,
  input  logic [BITS_REGS-1:0]      i_addr_rd,
  input  logic [BITS_REGS-1:0]      i_wb_addr_rd,
  input  logic [BITS_REGS-1:0]      i_tx_adrr_reg_unitdebug,
  input  logic                      i_flag_wb_reg_write,
  input  logic [BITS_SIZE-1:0]      i_wb_data,
  input  logic [BITS_SIZE-1:0]      i_IFID_PC4,
  input  logic [BITS_JUMP-1:0]      i_IFID_JUMP,
  input  logic [BITS_INMEDIATE-1:0] i_id_inmediate,
  input  logic [1:0]                i_ctl_extension_mode,
  output logic [BITS_SIZE-1:0]      o_idex_rs,
  output logic [BITS_SIZE-1:0]      o_idex_rt,
  output logic [BITS_SIZE-1:0]      o_idex_ext,
  output logic [BITS_SIZE-1:0]      o_idex_jump,
  output logic [BITS_SIZE-1:0]      o_idex_pc4,
  output logic [BITS_REGS-1:0]      o_idex_rt_addr,
  output logic [BITS_REGS-1:0]      o_idex_rd_addr,
  output logic                      o_idex_mem_read,
  output logic                      o_idex_eq,
  output logic                      o_idex_valid,
  output logic                      o_stall,
  output logic [BITS_SIZE-1:0]      o_data_tx_debug
);

  localparam int EXT_W = BITS_SIZE - BITS_INMEDIATE;

  logic [BITS_SIZE-1:0] regs [REG_SIZE];
  logic                 wr_en;
  logic [BITS_SIZE-1:0] rs_raw, rt_raw, rs_val, rt_val;
  logic [BITS_SIZE-1:0] ext_val, jump_val;
  logic                 bubble;

  // Register 0 is never written, so it stays at its reset value of zero.
  assign wr_en = i_step && i_flag_wb_reg_write && (i_wb_addr_rd != '0)
                 && (int'(i_wb_addr_rd) < REG_SIZE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < REG_SIZE; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[i_wb_addr_rd] <= i_wb_data;
    end
  end

  always_comb begin
    rs_raw          = '0;
    rt_raw          = '0;
    o_data_tx_debug = '0;
    if (i_addr_rs != '0 && int'(i_addr_rs) < REG_SIZE) rs_raw = regs[i_addr_rs];
    if (i_addr_rt != '0 && int'(i_addr_rt) < REG_SIZE) rt_raw = regs[i_addr_rt];
    if (int'(i_tx_adrr_reg_unitdebug) < REG_SIZE) o_data_tx_debug = regs[i_tx_adrr_reg_unitdebug];
  end

`ifdef ID_STAGE_BYPASS_EN
  // wr_en already excludes register 0, so a zero source address is never forwarded.
  assign rs_val = (wr_en && i_wb_addr_rd == i_addr_rs) ? i_wb_data : rs_raw;
  assign rt_val = (wr_en && i_wb_addr_rd == i_addr_rt) ? i_wb_data : rt_raw;
`else
  assign rs_val = rs_raw;
  assign rt_val = rt_raw;
`endif

  always_comb begin
    case (i_ctl_extension_mode)
      2'b00:   ext_val = {{EXT_W{i_id_inmediate[BITS_INMEDIATE-1]}}, i_id_inmediate};
      2'b01:   ext_val = {{EXT_W{1'b0}}, i_id_inmediate};
      2'b10:   ext_val = {i_id_inmediate, {EXT_W{1'b0}}};
      default: ext_val = '0;
    endcase
  end

  assign jump_val = {i_IFID_PC4[BITS_SIZE-1:BITS_JUMP+2], i_IFID_JUMP, 2'b00};

  assign o_stall = o_idex_valid && o_idex_mem_read && (o_idex_rt_addr != '0)
                   && ((o_idex_rt_addr == i_addr_rs) || (o_idex_rt_addr == i_addr_rt))
                   && i_valid;

  assign bubble = i_flush || o_stall || !i_valid;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_idex_rs       <= '0;
      o_idex_rt       <= '0;
      o_idex_ext      <= '0;
      o_idex_jump     <= '0;
      o_idex_pc4      <= '0;
      o_idex_rt_addr  <= '0;
      o_idex_rd_addr  <= '0;
      o_idex_mem_read <= 1'b0;
      o_idex_eq       <= 1'b0;
      o_idex_valid    <= 1'b0;
    end else if (i_step) begin
      if (bubble) begin
        o_idex_rs       <= '0;
        o_idex_rt       <= '0;
        o_idex_ext      <= '0;
        o_idex_jump     <= '0;
        o_idex_pc4      <= '0;
        o_idex_rt_addr  <= '0;
        o_idex_rd_addr  <= '0;
        o_idex_mem_read <= 1'b0;
        o_idex_eq       <= 1'b0;
        o_idex_valid    <= 1'b0;
      end else begin
        o_idex_rs       <= rs_val;
        o_idex_rt       <= rt_val;
        o_idex_ext      <= ext_val;
        o_idex_jump     <= jump_val;
        o_idex_pc4      <= i_IFID_PC4;
        o_idex_rt_addr  <= i_addr_rt;
        o_idex_rd_addr  <= i_addr_rd;
        o_idex_mem_read <= i_mem_read;
        o_idex_eq       <= (rs_val == rt_val);
        o_idex_valid    <= 1'b1;
      end
    end
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter BITS_SIZE, default 32, datapath/register width.
REQ-002 Parameter BITS_REGS, default 5, register address width.
REQ-003 Parameter REG_SIZE, default 32, number of registers (≤ 2^BITS_REGS).
REQ-004 Parameter BITS_JUMP, default 26, jump index field width.
REQ-005 Parameter BITS_INMEDIATE, default 16, immediate width (< BITS_SIZE).
REQ-006 Ports, in order: i_clk in 1, sole clock; i_reset in 1, asynchronous active-high reset; i_step in 1, global advance enable.
REQ-007 More inputs: i_flush 1, squash; i_valid 1, IF/ID holds an instruction; i_mem_read 1, decoded instruction is a load.
REQ-008 More inputs: i_addr_rs, i_addr_rt, i_addr_rd, i_wb_addr_rd, i_tx_adrr_reg_unitdebug, BITS_REGS each.
REQ-009 More inputs: i_flag_wb_reg_write 1; i_wb_data BITS_SIZE; i_IFID_PC4 BITS_SIZE; i_IFID_JUMP BITS_JUMP; i_id_inmediate BITS_INMEDIATE; i_ctl_extension_mode 2.
REQ-010 Outputs: o_idex_rs, o_idex_rt, o_idex_ext, o_idex_jump, o_idex_pc4, all BITS_SIZE, registered operand/immediate/target/PC+4.
REQ-011 Outputs: o_idex_rt_addr, o_idex_rd_addr BITS_REGS; o_idex_mem_read 1; o_idex_eq 1 (rs==rt); o_idex_valid 1; all registered.
REQ-012 Outputs: o_stall 1, combinational load-use stall request; o_data_tx_debug BITS_SIZE, combinational debug read.

Function
REQ-013 Register bank SHALL hold REG_SIZE words; write on i_clk rising edge when i_step & i_flag_wb_reg_write & i_wb_addr_rd≠0.
REQ-014 Register 0 SHALL always read 0; writes to it SHALL be ignored.
REQ-015 o_data_tx_debug SHALL return the stored value of register i_tx_adrr_reg_unitdebug, never bypassed; addresses ≥ REG_SIZE read 0.
REQ-016 Extension: mode 00 sign-extend, 01 zero-extend, 10 immediate shifted left by BITS_SIZE-BITS_INMEDIATE (zero-fill low), 11 all zeros.
REQ-017 Jump target SHALL be {i_IFID_PC4[BITS_SIZE-1:BITS_JUMP+2], i_IFID_JUMP, 2'b00}.
REQ-018 o_stall SHALL be 1 when o_idex_valid & o_idex_mem_read & o_idex_rt_addr≠0 & (o_idex_rt_addr==i_addr_rs | o_idex_rt_addr==i_addr_rt) & i_valid.
REQ-019 On rising edge with i_step=1: if i_flush or o_stall or !i_valid, ID/EX SHALL load a bubble (all outputs 0, valid 0); else load decoded values, valid 1; latency one step.
REQ-020 With i_step=0 all ID/EX registers and the bank SHALL hold; i_flush SHALL take effect only with i_step.
REQ-021 i_flush and o_stall simultaneous: bubble (flush wins, identical result).
REQ-022 o_idex_eq SHALL compare the (bypassed) rs and rt read values at the load edge.

Reset
REQ-023 i_reset asserted SHALL immediately clear all bank registers and all ID/EX outputs to 0, regardless of i_clk/i_step.
REQ-024 Reset mid-stall SHALL drop o_stall to 0 (o_idex_valid=0); first post-reset step SHALL decode normally.

Configuration
REQ-025 With ID_STAGE_BYPASS_EN defined: if a bank write (REQ-013 conditions) targets i_addr_rs/i_addr_rt (≠0) in the same cycle, the read SHALL return i_wb_data.
REQ-026 Without ID_STAGE_BYPASS_EN: reads SHALL return the pre-write stored value; software inserts a bubble.

Verification
REQ-027 Reset, write R5=0x0000_1234 via WB, debug addr 5 -> o_data_tx_debug=0x0000_1234; write R0=0xFFFF_FFFF -> R0 reads 0.
REQ-028 imm 0x8001, modes 00/01/10/11 -> o_idex_ext 0xFFFF_8001 / 0x0000_8001 / 0x8001_0000 / 0x0000_0000 after one step.
REQ-029 Load with rt=3 in ID/EX, next instr rs=3 -> o_stall=1, next step o_idex_valid=0; following step instr issues with valid=1.
REQ-030 Same-cycle WB R7=0xCAFE_0001 and read rs=7 -> o_idex_rs=0xCAFE_0001 with ID_STAGE_BYPASS_EN, old value without.
REQ-031 PC4=0xA000_0010, jump 0x00_0040 -> o_idex_jump=0xA000_0100; i_step=0 for 3 cycles -> outputs unchanged.
REQ-032 i_reset pulse mid-operation with R5 loaded and o_stall=1 -> all outputs and R5 read 0, o_stall=0 without a clock edge.
